proc_run_ctrl: RTL
==================

// Module: proc_run_ctrl
// PURPOSE
//  Run/reset sequencer for the processor core. Waits for a stable clock-wizard lock, then drives a clean
//  multi-cycle processor reset, then gates execution through a clock-enable (run / single-step / pause).
//  Stops the core on the HLT opcode and counts executed cycles. Sits between clk_wiz_0 and processor in full_top.
// PARAMETERS
//  BITS         16   instruction width (pm_rom data width)
//  OPBITS       5    opcode field width = instr[BITS-1 -: OPBITS]
//  HLT_OPCODE   5'd0 opcode value that halts execution
//  LOCK_STABLE  4    consecutive cycles i_locked must be high before reset release starts (>=1)
//  RST_CYCLES   8    cycles o_proc_reset is held after lock is stable (>=1)
//  CNT_BITS     32   width of executed-cycle counter
// PORTS
//  i_clock      in   1         clk_out1 domain clock
//  i_reset      in   1         async, active-high; forces WAIT_LOCK
//  i_locked     in   1         clk_wiz_0 locked (synchronous to i_clock)
//  i_instr      in   BITS      instruction currently fetched from pm_rom (combinational from PC)
//  i_run        in   1         level; start/continue free-running execution
//  i_step       in   1         single-cycle pulse; execute exactly one instruction
//  i_pause      in   1         level; stop free-running execution (resumable)
//  i_restart    in   1         single-cycle pulse; re-reset processor and return to IDLE
//  o_proc_reset out  1         reset to processor core, active-high
//  o_clk_en     out  1         processor clock enable (one instruction per enabled cycle)
//  o_state      out  3         current state encoding (see below)
//  o_halted     out  1         high in HALTED
//  o_cycles     out  CNT_BITS  executed (enabled) cycles since last reset release, saturating
// BEHAVIOUR
//  States: WAIT_LOCK=0, RST_HOLD=1, IDLE=2, RUN=3, STEP=4, HALTED=5. Single registered state machine.
//  Reset (async): state=WAIT_LOCK, lock counter=0, reset counter=0, o_cycles=0; o_proc_reset=1, o_clk_en=0, o_halted=0.
//  o_proc_reset = (state==WAIT_LOCK || state==RST_HOLD); o_halted = (state==HALTED); both decoded from state reg.
//  hlt = (i_instr[BITS-1 -: OPBITS] == HLT_OPCODE).
//  o_clk_en = (state==RUN || state==STEP) && !hlt && !(state==RUN && i_pause) && i_locked  (combinational).
//  => the HLT instruction itself is never executed; PC stays on it.
//  WAIT_LOCK: lock counter +1 per cycle while i_locked, cleared when low; at count==LOCK_STABLE-1 with
//    i_locked high -> RST_HOLD (reset counter cleared).
//  RST_HOLD: o_cycles cleared; after RST_CYCLES cycles in state -> IDLE.
//  IDLE: i_run -> RUN; else i_step -> STEP (run wins if both); else stay.
//  RUN: hlt -> HALTED; else i_pause -> IDLE; else stay.
//  STEP: one cycle only; hlt -> HALTED; else -> IDLE.
//  HALTED: stays; i_run / i_step / i_pause ignored; only i_restart leaves.
//  Global transitions, priority highest first, evaluated every cycle:
//    1. i_locked low in any state other than WAIT_LOCK -> WAIT_LOCK, lock counter cleared.
//    2. i_restart in IDLE/RUN/STEP/HALTED -> RST_HOLD (ignored in WAIT_LOCK and RST_HOLD).
//    3. per-state rules above.
//  o_cycles: +1 on every cycle with o_clk_en=1; saturates at all-ones (no wrap); cleared only in RST_HOLD/async reset.
//  Latency: i_run high in IDLE -> first o_clk_en one cycle later. Pause is immediate (same-cycle gate).
//  After i_reset deassert with i_locked constantly high: o_proc_reset falls after LOCK_STABLE+RST_CYCLES edges.
// TESTING
//  1. i_locked high from reset release, defaults -> o_proc_reset high 12 cycles, then IDLE, o_clk_en=0, o_cycles=0.
//  2. IDLE, i_run held, i_instr opcode=5'd3 for 10 cycles then 5'd0 -> o_clk_en 10 cycles, HALTED, o_cycles=10,
//     o_clk_en=0 while HLT present; i_run/i_step in HALTED change nothing.
//  3. IDLE, three i_step pulses 4 cycles apart, non-HLT opcode -> exactly 3 single-cycle o_clk_en pulses, o_cycles=3.
//  4. RUN, i_pause high 1 cycle -> o_clk_en low that same cycle, state IDLE next; i_run again resumes, count continues.
//  5. RUN, drop i_locked for 1 cycle -> o_clk_en low immediately, WAIT_LOCK, full LOCK_STABLE+RST_CYCLES sequence
//     repeats, o_cycles cleared; lock glitch shorter than LOCK_STABLE in WAIT_LOCK restarts lock count.
//  6. HALTED, i_restart pulse -> RST_HOLD 8 cycles with o_proc_reset=1, then IDLE; i_restart+i_locked low same
//     cycle -> WAIT_LOCK wins; async i_reset mid-RUN -> outputs at reset values without clock edge.

Source files
------------

// File: rtl/proc_run_ctrl.sv
// Run/reset sequencer: waits for a stable clock lock, holds the core in reset,
// then gates execution via a clock enable (run / step / pause) until HLT.
module proc_run_ctrl #(
  parameter int                 BITS        = 16,
  parameter int                 OPBITS      = 5,
  parameter logic [OPBITS-1:0]  HLT_OPCODE  = '0,
  parameter int                 LOCK_STABLE = 4,
  parameter int                 RST_CYCLES  = 8,
  parameter int                 CNT_BITS    = 32
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_locked,
  input  logic [BITS-1:0]     i_instr,
  input  logic                i_run,
  input  logic                i_step,
  input  logic                i_pause,
  input  logic                i_restart,
  output logic                o_proc_reset,
  output logic                o_clk_en,
  output logic [2:0]          o_state,
  output logic                o_halted,
  output logic [CNT_BITS-1:0] o_cycles
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    RST_HOLD  = 3'd1,
    IDLE      = 3'd2,
    RUN       = 3'd3,
    STEP      = 3'd4,
    HALTED    = 3'd5
  } state_e;

  localparam int LW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam int RW = (RST_CYCLES  > 1) ? $clog2(RST_CYCLES)  : 1;
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_STABLE - 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_ONE  = LW'(1);
  localparam logic [RW-1:0] RST_ONE   = RW'(1);

  state_e        state_q, state_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [RW-1:0] rst_q, rst_d;
  logic          hlt;
  logic          instr_unused;

  assign hlt          = (i_instr[BITS-1 -: OPBITS] == HLT_OPCODE);
  assign instr_unused = ^i_instr[BITS-OPBITS-1:0];

  // Gate is combinational so pause/lock loss/HLT stop the core in the same cycle.
  assign o_clk_en     = ((state_q == RUN) || (state_q == STEP)) && !hlt &&
                        !((state_q == RUN) && i_pause) && i_locked;
  assign o_proc_reset = (state_q == WAIT_LOCK) || (state_q == RST_HOLD);
  assign o_halted     = (state_q == HALTED);
  assign o_state      = state_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= WAIT_LOCK;
      lock_q  <= '0;
      rst_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rst_q   <= rst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rst_d   = rst_q;
    if (state_q != WAIT_LOCK && !i_locked) begin
      state_d = WAIT_LOCK;
      lock_d  = '0;
    end else if (i_restart && (state_q inside {IDLE, RUN, STEP, HALTED})) begin
      state_d = RST_HOLD;
      rst_d   = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (!i_locked) begin
            lock_d = '0;
          end else if (lock_q == LOCK_LAST) begin
            state_d = RST_HOLD;
            rst_d   = '0;
          end else begin
            lock_d = lock_q + LOCK_ONE;
          end
        end
        RST_HOLD: begin
          if (rst_q == RST_LAST) state_d = IDLE;
          else                   rst_d   = rst_q + RST_ONE;
        end
        IDLE: begin
          if      (i_run)  state_d = RUN;
          else if (i_step) state_d = STEP;
        end
        RUN: begin
          if      (hlt)     state_d = HALTED;
          else if (i_pause) state_d = IDLE;
        end
        STEP:    state_d = hlt ? HALTED : IDLE;
        HALTED:  state_d = HALTED;
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  // Saturating count of enabled cycles; only a reset hold clears it.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                        o_cycles <= '0;
    else if (state_q == RST_HOLD)       o_cycles <= '0;
    else if (o_clk_en && !(&o_cycles))  o_cycles <= o_cycles + 1'b1;
  end

endmodule
